// File: rtl/load_extend.sv
// Load-path lane extraction: tracks outstanding load metadata, extracts and
// sign/zero-extends the selected field of each in-order read word, and hands results to writeback.
module load_extend #(
  parameter int unsigned DEPTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [1:0]    req_size,
  input  logic [1:0]    req_addr_lo,
  input  logic          req_unsigned,
  input  logic          resp_valid,
  output logic          resp_ready,
  input  logic [31:0]   resp_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [31:0]   out_data,
  output logic          out_misalign,
  output logic [CW-1:0] pending
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [1:0]       size_q [DEPTH];
  logic [1:0]       size_d [DEPTH];
  logic [1:0]       off_q  [DEPTH];
  logic [1:0]       off_d  [DEPTH];
  logic [DEPTH-1:0] uns_q, uns_d;
  logic [DEPTH-1:0] kill_q, kill_d;
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    pending_q, pending_d;
  logic             out_valid_q, out_valid_d;
  logic [31:0]      out_data_q, out_data_d;
  logic             out_mis_q, out_mis_d;

  logic        push, pop, live_pop;
  logic [1:0]  head_size, head_off;
  logic        head_uns, head_kill;
  logic [7:0]  byte_v;
  logic [15:0] half_v;
  logic [31:0] ext_data;
  logic        ext_mis;

  assign head_size = size_q[rd_ptr_q];
  assign head_off  = off_q[rd_ptr_q];
  assign head_uns  = uns_q[rd_ptr_q];
  assign head_kill = kill_q[rd_ptr_q];

  assign req_ready  = !flush && (pending_q < CW'(DEPTH));
  assign resp_ready = (pending_q != '0) && (head_kill || !out_valid_q || out_ready);
  assign push       = req_valid && req_ready;
  assign pop        = resp_valid && resp_ready;
  assign live_pop   = pop && !head_kill && !flush;

  always_comb begin
    ext_data = '0;
    ext_mis  = 1'b0;
    byte_v   = '0;
    half_v   = '0;
    case (head_size)
      2'd0: begin
        case (head_off)
          2'd0:    byte_v = resp_data[7:0];
          2'd1:    byte_v = resp_data[15:8];
          2'd2:    byte_v = resp_data[23:16];
          default: byte_v = resp_data[31:24];
        endcase
        ext_data = {{24{byte_v[7] & ~head_uns}}, byte_v};
      end
      2'd1: begin
        if (head_off[0]) begin
          ext_mis = 1'b1;
        end else begin
          half_v   = head_off[1] ? resp_data[31:16] : resp_data[15:0];
          ext_data = {{16{half_v[15] & ~head_uns}}, half_v};
        end
      end
      2'd2: begin
        if (head_off == 2'd0) ext_data = resp_data;
        else                  ext_mis  = 1'b1;
      end
      default: ext_mis = 1'b1;
    endcase
  end

  always_comb begin
    size_d    = size_q;
    off_d     = off_q;
    uns_d     = uns_q;
    kill_d    = kill_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    pending_d = pending_q + CW'(push) - CW'(pop);
    // Only entries within the live window (head .. head+pending-1) are marked.
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (flush && (((i + DEPTH - 32'(rd_ptr_q)) % DEPTH) < 32'(pending_q)))
        kill_d[i] = 1'b1;
    end
    if (push) begin
      size_d[wr_ptr_q] = req_size;
      off_d[wr_ptr_q]  = req_addr_lo;
      uns_d[wr_ptr_q]  = req_unsigned;
      kill_d[wr_ptr_q] = 1'b0;
      wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
    end
    if (pop)
      rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
  end

  always_comb begin
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_mis_d   = out_mis_q;
    if (flush) begin
      out_valid_d = 1'b0;
    end else if (live_pop) begin
      out_valid_d = 1'b1;
      out_data_d  = ext_data;
      out_mis_d   = ext_mis;
    end else if (out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        size_q[i] <= '0;
        off_q[i]  <= '0;
      end
      uns_q       <= '0;
      kill_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      pending_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_mis_q   <= 1'b0;
    end else begin
      size_q      <= size_d;
      off_q       <= off_d;
      uns_q       <= uns_d;
      kill_q      <= kill_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      pending_q   <= pending_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_mis_q   <= out_mis_d;
    end
  end

  assign out_valid    = out_valid_q;
  assign out_data     = out_data_q;
  assign out_misalign = out_mis_q;
  assign pending      = pending_q;

endmodule

// File: tb/tb_load_extend.sv
// Scoreboard bench for load_extend: a queue-based reference model predicts handshakes,
// occupancy and extended results; a monitor compares results as the DUT presents them.
module tb_load_extend;
  localparam int unsigned DEPTH = 2;
  localparam int unsigned CW    = $clog2(DEPTH + 1);

  logic          clk, rst_n, flush;
  logic          req_valid, req_ready;
  logic [1:0]    req_size, req_addr_lo;
  logic          req_unsigned;
  logic          resp_valid, resp_ready;
  logic [31:0]   resp_data;
  logic          out_valid, out_ready;
  logic [31:0]   out_data;
  logic          out_misalign;
  logic [CW-1:0] pending;

  load_extend #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_size(req_size),
    .req_addr_lo(req_addr_lo), .req_unsigned(req_unsigned),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_misalign(out_misalign), .pending(pending)
  );

  typedef struct {
    logic [1:0]  sz;
    logic [1:0]  off;
    bit          uns;
    logic [31:0] w;
    bit          hg;
    logic [31:0] g;
    bit          gm;
    bit          kill;
  } meta_t;

  typedef struct {
    logic [31:0] d;
    bit          m;
  } res_t;

  meta_t       meta_q[$];
  res_t        exp_q[$];
  logic [31:0] mem_q[$];

  int checks = 0;
  int errors = 0;
  int mem_rate = 0;
  bit rand_or = 0;
  logic [31:0] rq_word, rq_gold;
  bit          rq_hg, rq_gm;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=0x%08h required=0x%08h t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference: pick the field by shifting, then sign-extend by subtracting 2^bits.
  task automatic ref_load(input logic [1:0] sz, input logic [1:0] off, input bit uns,
                          input logic [31:0] w, output logic [31:0] d, output bit mis);
    int unsigned     bits;
    bit              legal;
    longint unsigned v;
    case (sz)
      2'd0:    begin bits = 8;  legal = 1'b1; end
      2'd1:    begin bits = 16; legal = (off == 2'd0) || (off == 2'd2); end
      2'd2:    begin bits = 32; legal = (off == 2'd0); end
      default: begin bits = 32; legal = 1'b0; end
    endcase
    if (!legal) begin
      d = '0;
      mis = 1'b1;
    end else begin
      v = {32'd0, w};
      v = (v >> (8 * int'(off))) & ((64'd1 << bits) - 64'd1);
      if (!uns && v >= (64'd1 << (bits - 1))) v = v - (64'd1 << bits);
      d = v[31:0];
      mis = 1'b0;
    end
  endtask

  task automatic model_step();
    bit          e_req_ready, e_resp_ready, hk;
    meta_t       m;
    res_t        r;
    logic [31:0] d;
    bit          mis;
    hk           = (meta_q.size() != 0) && meta_q[0].kill;
    e_req_ready  = !flush && (meta_q.size() < DEPTH);
    e_resp_ready = (meta_q.size() != 0) && (hk || exp_q.size() == 0 || out_ready);
    chk("req_ready", 32'(req_ready), 32'(e_req_ready));
    chk("resp_ready", 32'(resp_ready), 32'(e_resp_ready));
    chk("pending", 32'(pending), 32'(meta_q.size()));
    if (flush) begin
      foreach (meta_q[i]) meta_q[i].kill = 1'b1;
      exp_q.delete();
    end
    if (resp_valid && e_resp_ready) begin
      m = meta_q.pop_front();
      void'(mem_q.pop_front());
      if (!m.kill) begin
        if (m.hg) begin
          d = m.g;
          mis = m.gm;
        end else begin
          ref_load(m.sz, m.off, m.uns, m.w, d, mis);
        end
        r.d = d;
        r.m = mis;
        exp_q.push_back(r);
      end
    end
    if (req_valid && e_req_ready) begin
      m.sz = req_size;
      m.off = req_addr_lo;
      m.uns = req_unsigned;
      m.w = rq_word;
      m.hg = rq_hg;
      m.g = rq_gold;
      m.gm = rq_gm;
      m.kill = 1'b0;
      meta_q.push_back(m);
      mem_q.push_back(rq_word);
    end
  endtask

  initial forever begin
    @(negedge clk);
    #1;
    if (!rst_n) begin
      meta_q.delete();
      exp_q.delete();
      mem_q.delete();
    end else begin
      model_step();
    end
  end

  // Monitor: any cycle a result is owed, the output register must show it.
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (exp_q.size() != 0) begin
        chk("out_valid", 32'(out_valid), 32'd1);
        chk("out_data", out_data, exp_q[0].d);
        chk("out_misalign", 32'(out_misalign), 32'(exp_q[0].m));
        if (out_valid && out_ready) void'(exp_q.pop_front());
      end else begin
        chk("out_valid_idle", 32'(out_valid), 32'd0);
      end
    end
  end

  // Memory side: returns words in request order with a configurable rate.
  initial forever begin
    @(posedge clk);
    #2;
    if (!rst_n || mem_q.size() == 0) begin
      resp_valid = 1'b0;
    end else if (resp_valid || int'($urandom_range(0, 99)) < mem_rate) begin
      resp_valid = 1'b1;
      resp_data  = mem_q[0];
    end else begin
      resp_valid = 1'b0;
    end
  end

  initial forever begin
    @(posedge clk);
    #1;
    if (rand_or) out_ready = ($urandom_range(0, 3) != 0);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] sz, input logic [1:0] off, input bit uns,
                       input logic [31:0] w, input bit hg, input logic [31:0] g, input bit gm);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_size = sz;
    req_addr_lo = off;
    req_unsigned = uns;
    rq_word = w;
    rq_hg = hg;
    rq_gold = g;
    rq_gm = gm;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (req_ready) begin
        acc = 1'b1;
        break;
      end
    end
    if (!acc) begin
      checks++;
      errors++;
      $display("FAIL issue_timeout req_ready=0 required=1 t=%0t", $time);
    end
    tick();
    req_valid = 1'b0;
  endtask

  task automatic issue_rnd();
    issue(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
          $urandom, 1'b0, 32'd0, 1'b0);
  endtask

  task automatic drain();
    bit done = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      tick();
      if (meta_q.size() == 0 && exp_q.size() == 0) begin
        done = 1'b1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout outstanding=%0d results=%0d required=0", meta_q.size(), exp_q.size());
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_out_data"}, out_data, 32'd0);
    chk({tag, "_out_misalign"}, 32'(out_misalign), 32'd0);
    chk({tag, "_pending"}, 32'(pending), 32'd0);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_resp_ready"}, 32'(resp_ready), 32'd0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
    $fatal(1);
  end

  initial begin
    rst_n = 1'b1; flush = 1'b0; req_valid = 1'b0; req_size = '0; req_addr_lo = '0;
    req_unsigned = 1'b0; resp_valid = 1'b0; resp_data = '0; out_ready = 1'b1;
    rq_word = '0; rq_gold = '0; rq_hg = 1'b0; rq_gm = 1'b0;
    #1 rst_n = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();

    // Reference vectors with literal expected results.
    mem_rate = 100;
    issue(2'd0, 2'd0, 1'b0, 32'h80FF7F01, 1'b1, 32'h00000001, 1'b0);
    issue(2'd0, 2'd1, 1'b0, 32'h80FF7F01, 1'b1, 32'h0000007F, 1'b0);
    issue(2'd0, 2'd2, 1'b0, 32'h80FF7F01, 1'b1, 32'hFFFFFFFF, 1'b0);
    issue(2'd0, 2'd3, 1'b0, 32'h80FF7F01, 1'b1, 32'hFFFFFF80, 1'b0);
    issue(2'd0, 2'd0, 1'b1, 32'h80FF7F01, 1'b1, 32'h00000001, 1'b0);
    issue(2'd0, 2'd1, 1'b1, 32'h80FF7F01, 1'b1, 32'h0000007F, 1'b0);
    issue(2'd0, 2'd2, 1'b1, 32'h80FF7F01, 1'b1, 32'h000000FF, 1'b0);
    issue(2'd0, 2'd3, 1'b1, 32'h80FF7F01, 1'b1, 32'h00000080, 1'b0);
    issue(2'd1, 2'd0, 1'b0, 32'h8001FFFE, 1'b1, 32'hFFFFFFFE, 1'b0);
    issue(2'd1, 2'd2, 1'b0, 32'h8001FFFE, 1'b1, 32'hFFFF8001, 1'b0);
    issue(2'd1, 2'd2, 1'b1, 32'h8001FFFE, 1'b1, 32'h00008001, 1'b0);
    issue(2'd2, 2'd0, 1'b0, 32'h8001FFFE, 1'b1, 32'h8001FFFE, 1'b0);
    issue(2'd1, 2'd1, 1'b0, 32'h8001FFFE, 1'b1, 32'h00000000, 1'b1);
    drain();

    // Backpressure: third request blocked, second response stalled behind held output.
    out_ready = 1'b0;
    mem_rate = 0;
    issue_rnd();
    issue_rnd();
    fork
      issue_rnd();
      begin
        repeat (3) tick();
        mem_rate = 100;
        repeat (4) tick();
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two loads in flight, then a fresh load.
    mem_rate = 0;
    issue_rnd();
    issue_rnd();
    chk("flush_pending_before", 32'(pending), 32'd2);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    mem_rate = 100;
    drain();
    issue(2'd1, 2'd2, 1'b0, 32'h8001FFFE, 1'b1, 32'hFFFF8001, 1'b0);
    drain();

    // Flush coincident with a live pop.
    mem_rate = 0;
    issue_rnd();
    flush = 1'b1;
    mem_rate = 100;
    tick();
    flush = 1'b0;
    drain();

    // Streaming at full rate: push and pop share cycles.
    out_ready = 1'b1;
    mem_rate = 100;
    repeat (10) issue_rnd();
    drain();

    // Randomised traffic with random backpressure and occasional flushes.
    rand_or = 1'b1;
    mem_rate = 60;
    repeat (300) begin
      if ($urandom_range(0, 24) == 0) begin
        flush = 1'b1;
        tick();
        flush = 1'b0;
      end
      if ($urandom_range(0, 2) == 0) tick();
      issue_rnd();
    end
    rand_or = 1'b0;
    tick();
    out_ready = 1'b1;
    mem_rate = 100;
    drain();

    // Asynchronous reset while a result is held and two loads are outstanding.
    out_ready = 1'b0;
    mem_rate = 0;
    issue_rnd();
    issue_rnd();
    mem_rate = 100;
    repeat (3) tick();
    issue_rnd();
    mem_rate = 0;
    chk("pre_reset_out_valid", 32'(out_valid), 32'd1);
    chk("pre_reset_pending", 32'(pending), 32'd2);
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1 check_reset_outputs("async_reset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    tick();
    out_ready = 1'b1;
    mem_rate = 100;
    issue(2'd0, 2'd3, 1'b0, 32'h80FF7F01, 1'b1, 32'hFFFFFF80, 1'b0);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/load_extend.md
# load_extend

Load-path counterpart of the store lane-placement logic in the memory stage. It tracks outstanding load requests and consumes in-order 32-bit read words from the data-memory interface. For each word it extracts the byte, halfword or word selected by the original request's size and address offset, then sign- or zero-extends it into a `DType`. Results are handed to writeback through a registered valid/ready port. A pipeline flush kills all in-flight loads without losing response alignment.

## Interface
Parameters:
- `DEPTH`, default 2: maximum outstanding loads (metadata FIFO entries), ≥1.
- `CW`, default `$clog2(DEPTH+1)`: width of the occupancy count.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous active-low reset.
- `flush` in 1: kill all in-flight loads and the output register.
- `req_valid` in 1: load issued to memory this cycle.
- `req_ready` out 1: metadata slot available.
- `req_size` in 2: 0 byte, 1 half, 2 word, 3 illegal.
- `req_addr_lo` in 2: address bits [1:0].
- `req_unsigned` in 1: 1 means zero-extend, 0 means sign-extend.
- `resp_valid` in 1: read word available.
- `resp_ready` out 1: read word consumed this cycle.
- `resp_data` in 32: raw aligned read word (`DType`).
- `out_valid` out 1: extended result valid.
- `out_ready` in 1: writeback accepts.
- `out_data` out 32: extended result (`DType`).
- `out_misalign` out 1: result came from an illegal size/offset pair.
- `pending` out CW: live plus killed metadata entries.

## Operation
- Metadata FIFO: each entry holds {size, addr_lo, unsigned, kill}. Push on `req_valid && req_ready`; pop on `resp_valid && resp_ready`. Responses arrive in request order.
- `req_ready = !flush && (pending < DEPTH)`. A push and a pop in the same cycle leave `pending` unchanged. The pointers wrap modulo DEPTH.
- `resp_ready = (pending != 0) && (head.kill || !out_valid || out_ready)`. Killed entries always drain at once. There is no same-cycle bypass: a request pushed in cycle N can be popped in cycle N+1 at the earliest.
- A response arriving while `pending == 0` is never accepted (`resp_ready` stays 0). The protocol forbids this case.
- Extraction, where off = addr_lo:
  - size 0: byte `resp_data[8*off+7 : 8*off]`.
  - size 1: off 0 gives `[15:0]`, off 2 gives `[31:16]`.
  - size 2: off 0 gives the full word.
  - Extension: sign-extend from the MSB of the extracted field, or zero-extend if `unsigned`. The word case passes through unchanged.
  - Illegal cases (size 1 with off 1/3, size 2 with off ≠0, size 3): `out_data = 0`, `out_misalign = 1`.
- Pop of a live entry: load {data, misalign} into the output register and set `out_valid`.
- Pop of a killed entry: discard the data, leave the output register untouched.
- Output register: `out_valid` clears on `out_ready` unless a new pop reloads it in the same cycle. Data is held stable while `out_valid && !out_ready`.
- Flush:
  - Sets `kill` on every valid FIFO entry, including an entry being popped that cycle, whose result is discarded.
  - Clears `out_valid`. No push occurs in the flush cycle.
  - `pending` still counts killed entries until their responses drain.

## Timing
- Reset values: `out_valid=0`, `out_data=0`, `out_misalign=0`, `pending=0`, pointers 0, all kill bits 0. From these, `req_ready=1` and `resp_ready=0`.
- Latency from response handshake in cycle N to `out_valid` in cycle N+1 is 1 cycle.
- Sustained throughput is one load per cycle when `out_ready` is held high and DEPTH ≥ 2.
- Flush takes effect on the next edge. Killed entries drain at one per cycle as responses arrive, regardless of `out_ready`.
- Reset asserted mid-operation clears all state immediately. Any responses still outstanding are the memory side's responsibility to drop.

## Test plan
- Byte loads: `resp_data=0x80FF7F01`, offsets 0–3, `ld.b` → `0x00000001`, `0x0000007F`, `0xFFFFFFFF`, `0xFFFFFF80`. The same offsets with `ld.bu` → `0x01`, `0x7F`, `0xFF`, `0x80`.
- Halfword and word loads: `resp_data=0x8001FFFE`.
  - `ld.h` off 0 → `0xFFFFFFFE`; off 2 → `0xFFFF8001`.
  - `ld.hu` off 2 → `0x00008001`.
  - `ld.w` → `0x8001FFFE`.
  - `ld.h` off 1 → `out_data=0`, `out_misalign=1`.
- Backpressure with DEPTH=2:
  - Issue 3 requests back-to-back; the 3rd sees `req_ready=0` until the first pop.
  - Hold `out_ready=0`; the 2nd response stalls (`resp_ready=0`) and `out_data` stays stable.
  - Release `out_ready`; results emerge in order.
- Flush with 2 pending: assert `flush` for one cycle, then deliver 2 responses.
  - Both are consumed with no `out_valid`, and `pending` goes 2→1→0.
  - A new request issued after the flush returns its correct result next.
- Simultaneous events: push and pop in the same cycle keep `pending` constant. Flush coincident with a live pop discards that result and leaves `out_valid=0`.
- Reset: assert `rst_n=0` with `out_valid=1` and `pending=2`. All outputs return to their reset values asynchronously, before the next clock edge.
